// File: rtl/clk_health_fsm.sv
// rtl/clk_health_fsm.sv - frequency-window qualification and debounced clock health state machine
module clk_health_fsm #(
    parameter int RATE_W = 32,
    parameter int CNT_W  = 16,
    parameter int RUN_W  = 8
) (
    input  logic              clk_ref,
    input  logic              reset,
    input  logic [RATE_W-1:0] rate,
    input  logic              rate_valid,
    input  logic              locked,
    input  logic [RATE_W-1:0] cfg_rate_min,
    input  logic [RATE_W-1:0] cfg_rate_max,
    input  logic [RUN_W-1:0]  cfg_n_good,
    input  logic [RUN_W-1:0]  cfg_n_bad,
    input  logic              clear_latch,
    output logic [1:0]        state,
    output logic              alarm,
    output logic              alarm_latched,
    output logic [CNT_W-1:0]  fault_count,
    output logic [RATE_W-1:0] last_bad_rate
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_OK      = 2'd1,
        ST_WARN    = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t             cur_state, nxt_state;
    logic [RUN_W-1:0]   good_run, bad_run;
    logic [RUN_W-1:0]   nxt_good_run, nxt_bad_run;
    logic [RUN_W-1:0]   good_run_inc, bad_run_inc;
    logic [RUN_W-1:0]   n_good_eff, n_bad_eff;
    logic               locked_d;
    logic               lock_loss;
    logic               sample_good;
    logic               load_bad_rate;
    logic               fault_entry;
    logic               nxt_alarm_latched;
    logic [CNT_W-1:0]   nxt_fault_count;

    // An inverted window (min > max) can never satisfy both bounds, so every sample is bad.
    assign sample_good  = locked && (rate >= cfg_rate_min) && (rate <= cfg_rate_max);
    assign lock_loss    = locked_d && !locked;
    assign n_good_eff   = (cfg_n_good == '0) ? RUN_W'(1) : cfg_n_good;
    assign n_bad_eff    = (cfg_n_bad == '0) ? RUN_W'(1) : cfg_n_bad;
    assign good_run_inc = (good_run == '1) ? good_run : good_run + RUN_W'(1);
    assign bad_run_inc  = (bad_run == '1) ? bad_run : bad_run + RUN_W'(1);

    always_comb begin
        nxt_state     = cur_state;
        nxt_good_run  = good_run;
        nxt_bad_run   = bad_run;
        load_bad_rate = 1'b0;

        if (lock_loss) begin
            nxt_state    = ST_FAULT;
            nxt_good_run = '0;
            nxt_bad_run  = '0;
        end else if (rate_valid) begin
            if (sample_good) begin
                nxt_good_run = good_run_inc;
                nxt_bad_run  = '0;
                case (cur_state)
                    ST_UNKNOWN: if (good_run_inc >= n_good_eff) nxt_state = ST_OK;
                    ST_WARN:    nxt_state = ST_OK;
                    ST_FAULT:   if (good_run_inc >= n_good_eff) nxt_state = ST_OK;
                    default:    nxt_state = cur_state;
                endcase
            end else begin
                nxt_good_run  = '0;
                nxt_bad_run   = bad_run_inc;
                load_bad_rate = 1'b1;
                case (cur_state)
                    ST_UNKNOWN: if (bad_run_inc >= n_bad_eff) nxt_state = ST_FAULT;
                    ST_OK:      nxt_state = (n_bad_eff == RUN_W'(1)) ? ST_FAULT : ST_WARN;
                    ST_WARN:    if (bad_run_inc >= n_bad_eff) nxt_state = ST_FAULT;
                    default:    nxt_state = cur_state;
                endcase
            end
        end
    end

    // Entering FAULT overrides a coincident clear so the new event is never lost.
    always_comb begin
        fault_entry       = (nxt_state == ST_FAULT) && (cur_state != ST_FAULT);
        nxt_alarm_latched = alarm_latched;
        nxt_fault_count   = fault_count;
        if (fault_entry) begin
            nxt_alarm_latched = 1'b1;
            if (clear_latch)
                nxt_fault_count = CNT_W'(1);
            else if (fault_count != '1)
                nxt_fault_count = fault_count + CNT_W'(1);
        end else if (clear_latch) begin
            nxt_alarm_latched = 1'b0;
            nxt_fault_count   = '0;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (reset) begin
            cur_state <= ST_UNKNOWN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (reset) begin
            good_run      <= '0;
            bad_run       <= '0;
            locked_d      <= 1'b0;
            alarm         <= 1'b0;
            alarm_latched <= 1'b0;
            fault_count   <= '0;
            last_bad_rate <= '0;
        end else begin
            good_run      <= nxt_good_run;
            bad_run       <= nxt_bad_run;
            locked_d      <= locked;
            alarm         <= (nxt_state == ST_FAULT);
            alarm_latched <= nxt_alarm_latched;
            fault_count   <= nxt_fault_count;
            if (load_bad_rate)
                last_bad_rate <= rate;
        end
    end

    assign state = cur_state;

endmodule

// File: doc/clk_health_fsm.md
Name: clk_health_fsm

Overview:
- Downstream consumer of the per-clock frequency measurement and synchronized lock status.
- Qualifies each new measurement against a programmable frequency window and debounces the result through a health state machine.
- Raises a live alarm, a sticky alarm and a fault counter for register readback and interrupt generation.
- Sits in the clk_ref domain; one instance per monitored clock.

Parameters:
- RATE_W, 32, width of rate measurement and window bounds (Hz count per measure period)
- CNT_W, 16, width of fault_count
- RUN_W, 8, width of debounce thresholds and run counters

Ports:
- clk_ref  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- rate  in  RATE_W  latest frequency measurement
- rate_valid  in  1  one-cycle pulse: rate holds a new measurement
- locked  in  1  lock status, already synchronized to clk_ref
- cfg_rate_min  in  RATE_W  inclusive lower bound of the good window
- cfg_rate_max  in  RATE_W  inclusive upper bound of the good window
- cfg_n_good  in  RUN_W  consecutive good samples needed to declare OK (0 treated as 1)
- cfg_n_bad  in  RUN_W  consecutive bad samples needed to declare FAULT (0 treated as 1)
- clear_latch  in  1  one-cycle pulse: clears alarm_latched and fault_count
- state  out  2  0=UNKNOWN, 1=OK, 2=WARN, 3=FAULT
- alarm  out  1  state==FAULT
- alarm_latched  out  1  sticky fault indicator
- fault_count  out  CNT_W  number of entries into FAULT, saturating
- last_bad_rate  out  RATE_W  rate value of the most recent bad sample

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs):
  - state=UNKNOWN, alarm=0, alarm_latched=0, fault_count=0, last_bad_rate=0.
  - Run counters = 0; locked_d = 0.
- Sample classification (only when rate_valid=1):
  - good iff locked=1 and cfg_rate_min <= rate <= cfg_rate_max, unsigned compare.
  - Otherwise bad.
  - If cfg_rate_min > cfg_rate_max, every sample is bad.
- Latency:
  - state, alarm and last_bad_rate update on the clk_ref edge at which rate_valid is sampled.
  - The registered value is visible the following cycle.
  - Config is sampled combinationally with rate_valid; no shadowing.
- Run counters:
  - good_run and bad_run are RUN_W bits and saturate at all-ones.
  - A good sample increments good_run and zeroes bad_run.
  - A bad sample increments bad_run and zeroes good_run.
  - Thresholds are compared against the post-increment value.
  - Effective threshold is max(cfg,1).
- Transitions on a valid sample:
  - UNKNOWN: good_run reaches n_good -> OK; bad_run reaches n_bad -> FAULT; else stay.
  - OK: bad -> FAULT if n_bad==1, else WARN; good -> stay.
  - WARN: good -> OK; bad_run reaches n_bad -> FAULT; else stay.
  - FAULT: good_run reaches n_good -> OK; else stay.
- Lock loss:
  - A falling edge of locked (locked_d=1, locked=0) forces FAULT in that cycle from any state.
  - This preempts any rate_valid in the same cycle; run counters are zeroed.
  - A rising edge of locked takes no direct action.
- FAULT entry (any transition into FAULT from a non-FAULT state):
  - fault_count increments, saturating at all-ones.
  - alarm_latched is set.
  - Remaining in FAULT does not re-increment.
- last_bad_rate loads rate on every bad valid sample, including in FAULT.
- clear_latch:
  - Clears alarm_latched and fault_count.
  - If FAULT entry occurs in the same cycle, the result is alarm_latched=1 and fault_count=1 (entry wins over clear).
  - Does not change state.
- alarm is registered and equals (state==FAULT) at all times after reset.

Test Plan:
- Reset, min=99_000, max=101_000, n_good=3; three valid samples of 100_000 with locked=1 -> state UNKNOWN, UNKNOWN, OK; alarm=0; fault_count=0.
- From OK with n_bad=2: sample 50_000 -> WARN, last_bad_rate=50_000; then 100_000 -> OK; then 50_000 twice -> FAULT, alarm=1, alarm_latched=1, fault_count=1.
- From OK, drop locked with no rate_valid -> FAULT next cycle, fault_count increments by 1; further bad samples leave fault_count unchanged.
- In FAULT, pulse clear_latch in the same cycle as a lock-loss FAULT re-entry from OK -> alarm_latched=1, fault_count=1.
- cfg_n_bad=0, cfg_n_good=0: from OK, one bad sample -> FAULT directly; one good sample -> OK; boundary samples rate=99_000 and rate=101_000 are classified good.
- Assert reset while in FAULT with fault_count=5 -> next cycle state=UNKNOWN and all outputs 0; set min>max -> every sample bad, FAULT after n_bad samples.
